// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared constants for the round-robin arbiter in front of mux_str:
//   mux width, select width, FSM state encodings and a one-hot helper.
package mux_rr_arbiter_pkg;

  localparam int MUX_N     = 8;
  localparam int MUX_SEL_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [MUX_N-1:0] onehot(input logic [MUX_SEL_W-1:0] idx);
    return MUX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_str.sv
// mux_str
//   Structural 8:1 single-bit mux built as a three-level tree of 2:1 muxes.
//   Ports:
//     out       out : a[sel]
//     sel [2:0] in  : select
//     a   [7:0] in  : data inputs
module mux_str (
  output logic       out,
  input  logic [2:0] sel,
  input  logic [7:0] a
);

  logic [3:0] lvl1;
  logic [1:0] lvl2;

  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    assign lvl1[g] = sel[0] ? a[2*g+1] : a[2*g];
  end

  for (genvar g = 0; g < 2; g++) begin : g_lvl2
    assign lvl2[g] = sel[1] ? lvl1[2*g+1] : lvl1[2*g];
  end

  assign out = sel[2] ? lvl2[1] : lvl2[0];

endmodule

// File: rtl/rr_pick8.sv
// rr_pick8
//   Combinational round-robin search over eight request lines.
//   Ports:
//     req   [7:0] in  : request lines
//     start [2:0] in  : index with highest priority; search wraps 7 -> 0
//     idx   [2:0] out : first set request at or after start
//     any         out : at least one request is set (idx is meaningless otherwise)
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] start,
  output logic [2:0] idx,
  output logic       any
);

  logic [2:0] k;

  // Scan from the farthest offset down to offset 0 so the closest set
  // request (in wrap order from start) is the last to be written.
  always_comb begin
    idx = start;
    any = 1'b0;
    k   = start;
    for (int i = 7; i >= 0; i--) begin
      k = start + 3'(i);
      if (req[k]) begin
        idx = k;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter/sequencer sharing mux_str's single-bit output among
//   eight requesters. A grantee keeps the mux for up to HOLD_MAX beats while
//   it holds its request; on release the search restarts just past it.
//   Parameters:
//     HOLD_MAX (1..15) : maximum data beats per grant
//   Ports:
//     clk             in  : clock, rising edge
//     rst_n           in  : asynchronous active-low reset
//     req       [7:0] in  : per-requester level request
//     a         [7:0] in  : per-requester data bit
//     sel       [2:0] out : mux select, current or last grantee
//     gnt       [7:0] out : one-hot grant, zero when idle
//     out             out : registered a[sel] beat
//     out_valid       out : out carries a beat captured this cycle
//     busy            out : arbiter is in GRANT
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] a,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       out,
  output logic       out_valid,
  output logic       busy
);

  logic [0:0]           state;
  logic [MUX_SEL_W-1:0] ptr;
  logic [3:0]           hold_cnt;

  logic                 mux_bit;
  logic [MUX_SEL_W-1:0] start;
  logic [MUX_SEL_W-1:0] win;
  logic                 win_any;
  logic                 beat;
  logic                 last_beat;
  logic                 release_now;

  mux_str u_mux (
    .out (mux_bit),
    .sel (sel),
    .a   (a)
  );

  // While granted, the only search that matters is the release search,
  // which starts just past the grantee so it ends up lowest priority.
  assign start = (state == ST_GRANT) ? sel + 3'd1 : ptr;

  rr_pick8 u_pick (
    .req   (req),
    .start (start),
    .idx   (win),
    .any   (win_any)
  );

  // A dropped request wins over expiry: no beat on that edge.
  assign beat        = (state == ST_GRANT) && req[sel];
  assign last_beat   = beat && (hold_cnt == 4'(HOLD_MAX - 1));
  assign release_now = (state == ST_GRANT) && (!req[sel] || last_beat);
  assign busy        = (state == ST_GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      sel       <= '0;
      gnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= beat;
      if (beat) begin
        out      <= mux_bit;
        hold_cnt <= hold_cnt + 4'd1;
      end
      if (release_now) begin
        ptr <= sel + 3'd1;
      end
      // Arbitrate from IDLE or on release; a live request regrants with no bubble.
      if ((state == ST_IDLE) || release_now) begin
        if (win_any) begin
          state    <= ST_GRANT;
          sel      <= win;
          gnt      <= onehot(win);
          hold_cnt <= '0;
        end else begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] a;

  logic [2:0] sel4, sel2, sel3;
  logic [7:0] gnt4, gnt2, gnt3;
  logic       out4, out2, out3;
  logic       ov4, ov2, ov3;
  logic       busy4, busy2, busy3;

  int n_chk;
  int n_fail;

  mux_rr_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a),
    .sel(sel4), .gnt(gnt4), .out(out4), .out_valid(ov4), .busy(busy4)
  );

  mux_rr_arbiter #(.HOLD_MAX(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a),
    .sel(sel2), .gnt(gnt2), .out(out2), .out_valid(ov2), .busy(busy2)
  );

  mux_rr_arbiter #(.HOLD_MAX(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a),
    .sel(sel3), .gnt(gnt3), .out(out3), .out_valid(ov3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] wrap_exp [9];
  logic [7:0] exp_g;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req = 8'h00;
    a = 8'h00;
    wrap_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};

    // Reset state
    step();
    step();
    chk("rst_sel", 32'(sel4), 32'd0);
    chk("rst_gnt", 32'(gnt4), 32'h00);
    chk("rst_out", 32'(out4), 32'd0);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    rst_n = 1'b1;

    // Reset mid-grant
    req = 8'h04;
    a = 8'h04;
    step();
    chk("mid_gnt", 32'(gnt4), 32'h04);
    chk("mid_sel", 32'(sel4), 32'd2);
    chk("mid_busy", 32'(busy4), 32'd1);
    chk("mid_ov_setup", 32'(ov4), 32'd0);
    step();
    chk("mid_ov_beat", 32'(ov4), 32'd1);
    chk("mid_out_beat", 32'(out4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_gnt", 32'(gnt4), 32'h00);
    chk("mid_async_ov", 32'(ov4), 32'd0);
    chk("mid_async_sel", 32'(sel4), 32'd0);
    chk("mid_async_out", 32'(out4), 32'd0);
    chk("mid_async_busy", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid_regrant_gnt", 32'(gnt4), 32'h04);
    chk("mid_regrant_sel", 32'(sel4), 32'd2);
    do_reset();

    // Single requester, HOLD_MAX=4
    req = 8'h08;
    a = 8'hAF;
    step();
    chk("single_gnt", 32'(gnt4), 32'h08);
    chk("single_sel", 32'(sel4), 32'd3);
    chk("single_ov_setup", 32'(ov4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_ov", 32'(ov4), 32'd1);
      chk("single_out", 32'(out4), 32'd1);
      chk("single_gnt_hold", 32'(gnt4), 32'h08);
    end
    chk("single_busy", 32'(busy4), 32'd1);
    do_reset();

    // Rotation, req=FF, HOLD_MAX=2
    req = 8'hFF;
    a = 8'h5A;
    for (int i = 0; i < 9; i++) begin
      exp_g = 8'(1) << (i % 8);
      step();
      chk("rot_gnt_setup", 32'(gnt2), 32'(exp_g));
      chk("rot_sel", 32'(sel2), 32'(i % 8));
      step();
      chk("rot_gnt_beat", 32'(gnt2), 32'(exp_g));
      chk("rot_ov", 32'(ov2), 32'd1);
      chk("rot_out", 32'(out2), 32'(a[i % 8]));
    end
    do_reset();

    // Wrap-around, req=81
    req = 8'h81;
    a = 8'h00;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("wrap_gnt", 32'(gnt4), 32'(wrap_exp[i]));
    end
    do_reset();

    // Early drop with req[6] pending
    req = 8'h20;
    a = 8'h20;
    step();
    chk("drop_gnt5", 32'(gnt4), 32'h20);
    req = 8'h60;
    step();
    chk("drop_beat_ov", 32'(ov4), 32'd1);
    chk("drop_no_preempt", 32'(gnt4), 32'h20);
    req = 8'h40;
    step();
    chk("drop_ov", 32'(ov4), 32'd0);
    chk("drop_gnt6", 32'(gnt4), 32'h40);
    chk("drop_sel6", 32'(sel4), 32'd6);
    do_reset();

    // Simultaneous drop and expiry, HOLD_MAX=3
    req = 8'h02;
    a = 8'h02;
    step();
    chk("dx_gnt", 32'(gnt3), 32'h02);
    step();
    chk("dx_beat1", 32'(ov3), 32'd1);
    step();
    chk("dx_beat2", 32'(ov3), 32'd1);
    req = 8'h00;
    step();
    chk("dx_no_beat3", 32'(ov3), 32'd0);
    chk("dx_gnt_idle", 32'(gnt3), 32'h00);
    chk("dx_busy", 32'(busy3), 32'd0);
    chk("dx_sel_hold", 32'(sel3), 32'd1);
    chk("dx_out_hold", 32'(out3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
